// File: rtl/mul_pkg.sv
// Shared definitions for the time-shared 5x5 multiply unit.
package mul_pkg;

  localparam int W  = 5;
  localparam int PW = 2 * W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_shift_add.sv
// Shift-and-add multiply datapath: one multiplier bit per step, W steps per product.
module mul_shift_add
  import mul_pkg::*;
#(
  parameter int W = mul_pkg::W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
  output logic [2*W-1:0]   acc_nxt,
  output logic             last
);

  localparam int PROD_W = 2 * W;
  localparam int CW     = $clog2(W + 1);

  logic [W-1:0]      mcand_q;
  logic [W-1:0]      mplier_q;
  logic [PROD_W-1:0] acc_q;
  logic [PROD_W-1:0] acc_d;
  logic [PROD_W-1:0] partial;
  logic [CW-1:0]     cnt_q;

  // Partial product: multiplicand zero-extended to product width, weighted by bit index.
  always_comb begin
    partial = {{W{1'b0}}, mcand_q} << cnt_q;
    acc_d   = mplier_q[0] ? (acc_q + partial) : acc_q;
  end

  // Accumulator and bit counter; cleared on reset so an aborted product leaves no residue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (step) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Operand registers: multiplier shifts right so bit 0 is always the current bit.
  always_ff @(posedge clk) begin
    if (load) begin
      mcand_q  <= x;
      mplier_q <= y;
    end else if (step) begin
      mplier_q <= mplier_q >> 1;
    end
  end

  assign acc_nxt = acc_d;
  assign last    = (cnt_q == CW'(W - 1));

endmodule

// File: rtl/mul_share_ctrl.sv
// Two-requester round-robin front end around a sequential shift-and-add multiplier.
module mul_share_ctrl
  import mul_pkg::*;
#(
  parameter int W = mul_pkg::W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  input  logic [W-1:0]   req0_x,
  input  logic [W-1:0]   req0_y,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [W-1:0]   req1_x,
  input  logic [W-1:0]   req1_y,
  output logic           req1_ready,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [2*W-1:0] res,
  output logic           res_id,
  output logic           busy
);

  localparam int PROD_W = 2 * W;

  state_t            state_q, state_d;
  logic              prio_q;
  logic              id_q;
  logic              busy_q;
  logic [PROD_W-1:0] res_q;
  logic              res_id_q;

  logic              gnt_vld;
  logic              gnt_id;
  logic              load;
  logic              step;
  logic [W-1:0]      op_x;
  logic [W-1:0]      op_y;
  logic [PROD_W-1:0] acc_nxt;
  logic              last;

  // Arbitration: contention goes to the pointer, otherwise to whichever requester is valid.
  always_comb begin
    gnt_vld = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      gnt_id = prio_q;
    end else begin
      gnt_id = req1_valid;
    end
    op_x = gnt_id ? req1_x : req0_x;
    op_y = gnt_id ? req1_y : req0_y;
  end

  // Next-state and control decode; ready is only offered from IDLE outside reset.
  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    step       = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rst_n && gnt_vld) begin
          load       = 1'b1;
          req0_ready = ~gnt_id;
          req1_ready = gnt_id;
          state_d    = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      id_q     <= 1'b0;
      busy_q   <= 1'b0;
      res_q    <= '0;
      res_id_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      if (load) begin
        prio_q <= ~gnt_id;
        id_q   <= gnt_id;
      end
      if (step && last) begin
        res_q    <= acc_nxt;
        res_id_q <= id_q;
      end
    end
  end

  mul_shift_add #(
    .W (W)
  ) u_dp (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .step    (step),
    .x       (op_x),
    .y       (op_y),
    .acc_nxt (acc_nxt),
    .last    (last)
  );

  assign res_valid = (state_q == DONE);
  assign res       = res_q;
  assign res_id    = res_id_q;
  assign busy      = busy_q;

endmodule

// File: doc/mul_share_ctrl.md
# mul_share_ctrl

Sequential 5×5 unsigned multiply unit shared between two requesters. A round-robin arbiter accepts one operand pair at a time, an internal shift-and-add datapath produces the 10-bit product over W cycles, and the result is returned with a requester tag over a valid/ready handshake. It sits between the two operand sources and the result consumer, and provides the same `res = x * y` function as the existing combinational multiplier, time-shared.

## Interface
Parameters:
- `W`, 5, operand width; product width is 2·W.

Ports:
- `clk`, in, 1, rising-edge clock.
- `rst_n`, in, 1, synchronous active-low reset.
- `req0_valid`, in, 1, requester 0 has an operand pair.
- `req0_x`, `req0_y`, in, W, requester 0 operands, unsigned.
- `req0_ready`, out, 1, requester 0 pair accepted this cycle.
- `req1_valid`, `req1_x`, `req1_y`, `req1_ready`: same as requester 0, for requester 1.
- `res_valid`, out, 1, product available.
- `res_ready`, in, 1, consumer accepts the product.
- `res`, out, 2W, product x·y.
- `res_id`, out, 1, requester that issued the product.
- `busy`, out, 1, high whenever the state is not IDLE.

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **IDLE:**
  - If any `reqN_valid` is high, grant one requester.
  - `reqN_ready` is combinational: 1 only for the granted requester, only in IDLE, and only while `rst_n` is high.
  - On the handshake edge, capture `mcand <= x`, `mplier <= y`, `acc <= 0`, `cnt <= 0`, `id <= N`, then go to RUN.
- **Arbitration:** 1-bit priority pointer `prio`.
  - Both valid: grant `prio`.
  - One valid: grant that one.
  - After any grant, `prio <=` the other requester.
- **RUN**, once per cycle:
  - If `mplier[0]`, `acc <= acc + (mcand << cnt)`.
  - `mplier <= mplier >> 1`, `cnt <= cnt + 1`.
  - After the cycle with `cnt == W-1`, go to DONE.
  - RUN always lasts exactly W cycles. There is no early exit on zero operands.
- **Width rule:** `acc` is 2W bits, and the shifted multiplicand is zero-extended to 2W. Overflow is impossible because the maximum is 31·31 = 961 = 0x3C1.
- **DONE:**
  - `res_valid = 1`, `res = acc`, `res_id = id`.
  - On `res_valid & res_ready`, go to IDLE.
  - While `res_ready` is low, `res` and `res_id` hold stable and both `reqN_ready` stay 0.
- **After the handshake:** `res` and `res_id` keep their last value and `res_valid` is 0.
- **Requester inputs:** requests that arrive while the unit is busy are ignored. The requester must hold `valid` and its operands until it sees `ready`.
- **Reset, including mid-RUN or mid-DONE:** the operation is aborted and no `res_valid` is produced.
  - Reset values: state IDLE, `prio = 0`, `acc = 0`, `res = 0`, `res_id = 0`, `res_valid = 0`, `busy = 0`, `cnt = 0`.

## Timing
- **Accept:** accept cycle A is the cycle with `reqN_valid & reqN_ready` in IDLE.
- **Latency:**
  - RUN occupies cycles A+1 … A+W.
  - `res_valid` first goes high in cycle A+W+1 (A+6 for W=5).
  - Latency is fixed regardless of operand values.
- **Result handshake:** if `res_ready` is high in cycle A+W+1, `res_valid` is 0 in A+W+2, and that is the earliest next accept cycle.
- **Throughput:** peak is one product per W+2 cycles (7 for W=5).
- **`busy`:** registered; high from cycle A+1 through the result-handshake cycle inclusive.
- **Back-to-back requests:** with both requesters continuously valid, grants alternate 0,1,0,1…

## Structure
- **Package `mul_pkg`:**
  - `W` default constant.
  - State enum `{IDLE, RUN, DONE}`.
  - Product width constant `PW = 2*W`.
- **Sub-module `mul_shift_add`:**
  - Contains the `mcand`/`mplier`/`acc`/`cnt` datapath.
  - Control inputs: `load` and `step`. Output: `last`.
- **`mul_share_ctrl` itself:** holds the FSM, the round-robin pointer, and the output registers.

## Test plan
- **Single request, immediate consume:** reset 2 cycles, then `req0_valid=1`, x=3, y=7, `res_ready=1` → `req0_ready=1` in cycle A; `res_valid=1` in A+6 with `res=21`, `res_id=0`; `busy` high A+1…A+6.
- **Simultaneous requests:** after reset, both valid (req0 x=5 y=6, req1 x=9 y=4) → req0 granted first (`res=30`, `res_id=0`), then req1 (`res=36`, `res_id=1`); third grant goes to req0 if it is still valid.
- **Maximum operands:** x=31, y=31 → `res=961` (0x3C1) in A+6. Also check x=31, y=1 → 31 and x=1, y=31 → 31.
- **Consumer backpressure:** hold `res_ready=0` for 4 cycles in DONE with req1 valid → `res`/`res_id` stable and `req1_ready=0` throughout; req1 is accepted in the cycle after `res_ready` rises.
- **Reset mid-operation:** assert `rst_n=0` in cycle A+3 of x=12 y=10 → next cycle state is IDLE, `res_valid=0`, `res=0`, `busy=0`, `prio=0`; no result ever appears for that request.
- **Zero operands:** x=0, y=17 → `res=0` still at exactly A+6.
